// File: rtl/bldc_commutator.sv
// -----------------------------------------------------------------------------
// bldc_commutator
//
// Six-step BLDC commutation engine. It decodes debounced hall inputs into an
// electrical sector and drives the half-bridge gates from a forward/reverse
// pattern table. An all-off dead-time gap is inserted on every pattern change.
// Brake mode turns on all three low sides. An invalid hall code that persists
// latches a fault. The time between sector changes is measured.
//
// Optional feature macro: BLDC_COMMUTATOR_SEQ_CHECK_EN
//   When defined, every valid sector change is checked for a +/-1 step, and a
//   skip sets the sticky seq_error flag. When undefined, seq_error is tied to 0.
//
// Ports
//   CLK          system clock
//   reset        synchronous, active-high reset
//   enable       1 = drive motor, 0 = all gates off (no dead time needed)
//   dir          1 = forward table, 0 = reverse table
//   brake        1 = all low sides on (after a dead-time gap)
//   hall         debounced hall code {h1,h2,h3}
//   pwm_in       PWM gating applied to the high-side gates
//   dead_time    all-off gap length in CLK cycles (0 behaves as 1)
//   fault_clear  clears a latched fault when the hall code is valid
//   gh           high-side gates {C,B,A}
//   gl           low-side gates {C,B,A}
//   sector       effective sector 0..5
//   step_pulse   one-cycle pulse on each valid sector change
//   step_period  cycles between the last two sector changes (saturating)
//   fault        latched invalid-hall fault
//   seq_error    sticky hall-sequence error (optional feature)
// -----------------------------------------------------------------------------
module bldc_commutator #(
   parameter int DT_WIDTH     = 10,
   parameter int HALL_OFFSET  = 0,
   parameter int FAULT_CNT    = 16,
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    dir,
   input  logic                    brake,
   input  logic [2:0]              hall,
   input  logic                    pwm_in,
   input  logic [DT_WIDTH-1:0]     dead_time,
   input  logic                    fault_clear,
   output logic [2:0]              gh,
   output logic [2:0]              gl,
   output logic [2:0]              sector,
   output logic                    step_pulse,
   output logic [PERIOD_WIDTH-1:0] step_period,
   output logic                    fault,
   output logic                    seq_error
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DEADTIME = 3'd1;
   localparam logic [2:0] S_DRIVE    = 3'd2;
   localparam logic [2:0] S_BRAKE    = 3'd3;
   localparam logic [2:0] S_FAULT    = 3'd4;

   localparam int FC_W = $clog2(FAULT_CNT + 1);

   localparam logic [2:0] PH_A = 3'b001;
   localparam logic [2:0] PH_B = 3'b010;
   localparam logic [2:0] PH_C = 3'b100;

   // Returns {valid, sector_raw}; 000 and 111 are invalid.
   function automatic logic [3:0] decode_hall(input logic [2:0] h);
      logic [3:0] r;
      case (h)
         3'b101:  r = 4'b1_000;
         3'b100:  r = 4'b1_001;
         3'b110:  r = 4'b1_010;
         3'b010:  r = 4'b1_011;
         3'b011:  r = 4'b1_100;
         3'b001:  r = 4'b1_101;
         default: r = 4'b0_000;
      endcase
      return r;
   endfunction

   // (s + HALL_OFFSET) mod 6, with s and HALL_OFFSET both in 0..5.
   function automatic logic [2:0] rotate_sector(input logic [2:0] s);
      logic [3:0] t;
      t = {1'b0, s} + 4'(HALL_OFFSET);
      if (t >= 4'd6) t = t - 4'd6;
      return t[2:0];
   endfunction

   // Returns {high_mask, low_mask} for a sector; reverse swaps the phases.
   function automatic logic [5:0] pattern(input logic [2:0] s, input logic d);
      logic [5:0] p;
      case (s)
         3'd0:    p = {PH_C, PH_B};
         3'd1:    p = {PH_A, PH_B};
         3'd2:    p = {PH_A, PH_C};
         3'd3:    p = {PH_B, PH_C};
         3'd4:    p = {PH_B, PH_A};
         3'd5:    p = {PH_C, PH_A};
         default: p = 6'b000_000;
      endcase
      if (!d) p = {p[2:0], p[5:3]};
      return p;
   endfunction

   logic [3:0]              hall_dec;
   logic                    hall_valid;
   logic [2:0]              sector_eff;
   logic                    sector_chg;
   logic                    fault_set;
   logic                    fault_clr;
   logic                    fault_nxt;
   logic [FC_W-1:0]         inv_cnt;
   logic [PERIOD_WIDTH-1:0] period_cnt;

   logic [2:0]              state;
   logic [2:0]              gh_sel;
   logic [DT_WIDTH-1:0]     dt_cnt;
   logic [DT_WIDTH-1:0]     dt_load;
   logic [4:0]              tgt;
   logic [4:0]              tgt_now;
   logic                    tgt_chg;
   logic [5:0]              pat;

   assign hall_dec   = decode_hall(hall);
   assign hall_valid = hall_dec[3];
   assign sector_eff = rotate_sector(hall_dec[2:0]);
   assign sector_chg = hall_valid && (sector_eff != sector);

   // Fault decisions are taken combinationally so the FSM can force the gates
   // off on the same edge that latches the fault.
   assign fault_set = !hall_valid && (inv_cnt >= FC_W'(FAULT_CNT - 1));
   assign fault_clr = fault_clear && hall_valid;
   assign fault_nxt = fault_clr ? 1'b0 : (fault | fault_set);

   // ---- hall decode / period measurement / fault latch stage ----
   always_ff @(posedge CLK) begin
      if (reset) begin
         sector      <= 3'd0;
         step_pulse  <= 1'b0;
         step_period <= '0;
         period_cnt  <= '0;
         inv_cnt     <= '0;
         fault       <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (period_cnt != '1) period_cnt <= period_cnt + 1'b1;
         if (hall_valid) begin
            inv_cnt <= '0;
            if (sector_chg) begin
               sector      <= sector_eff;
               step_pulse  <= 1'b1;
               step_period <= period_cnt;
               period_cnt  <= PERIOD_WIDTH'(1);
            end
         end else if (inv_cnt != FC_W'(FAULT_CNT)) begin
            inv_cnt <= inv_cnt + 1'b1;
         end
         fault <= fault_nxt;
      end
   end

`ifdef BLDC_COMMUTATOR_SEQ_CHECK_EN
   function automatic logic is_adjacent(input logic [2:0] o, input logic [2:0] n);
      logic [2:0] up;
      logic [2:0] dn;
      up = (o == 3'd5) ? 3'd0 : o + 3'd1;
      dn = (o == 3'd0) ? 3'd5 : o - 3'd1;
      return (n == up) || (n == dn);
   endfunction

   logic seen_first;
   logic seq_err_q;

   // The reset value of sector is not a real hall position, so the first
   // decoded sector is never compared against it.
   always_ff @(posedge CLK) begin
      if (reset) begin
         seen_first <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         if (hall_valid) seen_first <= 1'b1;
         if (fault_clr) begin
            seq_err_q <= 1'b0;
         end else if (sector_chg && seen_first && !is_adjacent(sector, sector_eff)) begin
            seq_err_q <= 1'b1;
         end
      end
   end

   assign seq_error = seq_err_q;
`else
   assign seq_error = 1'b0;
`endif

   assign tgt_now = {sector, dir, brake};
   assign tgt_chg = (tgt_now != tgt);
   assign dt_load = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;
   assign pat     = pattern(sector, dir);

   // ---- commutation FSM / gate register stage ----
   // gh_sel and gl are always written together, so a high and low side of the
   // same phase can never be on in the same cycle.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state  <= S_IDLE;
         gh_sel <= 3'b000;
         gl     <= 3'b000;
         dt_cnt <= '0;
         tgt    <= '0;
      end else if (!enable) begin
         state  <= S_IDLE;
         gh_sel <= 3'b000;
         gl     <= 3'b000;
      end else if (fault_nxt) begin
         state  <= S_FAULT;
         gh_sel <= 3'b000;
         gl     <= 3'b000;
      end else begin
         case (state)
            S_IDLE: begin
               state  <= S_DEADTIME;
               dt_cnt <= dt_load;
               tgt    <= tgt_now;
               gh_sel <= 3'b000;
               gl     <= 3'b000;
            end
            S_DEADTIME: begin
               if (tgt_chg) begin
                  // Target moved while waiting: restart the full gap.
                  dt_cnt <= dt_load;
                  tgt    <= tgt_now;
               end else if (dt_cnt <= DT_WIDTH'(1)) begin
                  if (brake) begin
                     state  <= S_BRAKE;
                     gh_sel <= 3'b000;
                     gl     <= 3'b111;
                  end else begin
                     state  <= S_DRIVE;
                     gh_sel <= pat[5:3];
                     gl     <= pat[2:0];
                  end
               end else begin
                  dt_cnt <= dt_cnt - 1'b1;
               end
            end
            S_DRIVE: begin
               if (tgt_chg) begin
                  state  <= S_DEADTIME;
                  dt_cnt <= dt_load;
                  tgt    <= tgt_now;
                  gh_sel <= 3'b000;
                  gl     <= 3'b000;
               end
            end
            S_BRAKE: begin
               if (!brake) begin
                  state  <= S_DEADTIME;
                  dt_cnt <= dt_load;
                  tgt    <= tgt_now;
                  gh_sel <= 3'b000;
                  gl     <= 3'b000;
               end
            end
            S_FAULT: begin
               // Only reached here once the fault has been cleared.
               state  <= S_IDLE;
               gh_sel <= 3'b000;
               gl     <= 3'b000;
            end
            default: begin
               state  <= S_IDLE;
               gh_sel <= 3'b000;
               gl     <= 3'b000;
            end
         endcase
      end
   end

   assign gh = gh_sel & {3{pwm_in}};

endmodule

// File: tb/tb_bldc_commutator.sv
// -----------------------------------------------------------------------------
// tb_bldc_commutator
//
// Directed bench for bldc_commutator with default parameters (FAULT_CNT=16,
// HALL_OFFSET=0). Inputs change 1 time unit after a rising edge; outputs are
// examined at that same point, so each check sees the result of the edge just
// taken. Hall codes used: 101=s0, 100=s1, 110=s2. Gate masks are {C,B,A}.
// -----------------------------------------------------------------------------
module tb_bldc_commutator;

   logic        CLK = 1'b0;
   logic        reset;
   logic        enable;
   logic        dir;
   logic        brake;
   logic [2:0]  hall;
   logic        pwm_in;
   logic [9:0]  dead_time;
   logic        fault_clear;
   logic [2:0]  gh;
   logic [2:0]  gl;
   logic [2:0]  sector;
   logic        step_pulse;
   logic [23:0] step_period;
   logic        fault;
   logic        seq_error;

   int total = 0;
   int bad   = 0;

`ifdef BLDC_COMMUTATOR_SEQ_CHECK_EN
   localparam logic [31:0] EXP_SEQ = 32'd1;
`else
   localparam logic [31:0] EXP_SEQ = 32'd0;
`endif

   always #5 CLK = ~CLK;

   bldc_commutator #(
      .DT_WIDTH    (10),
      .HALL_OFFSET (0),
      .FAULT_CNT   (16),
      .PERIOD_WIDTH(24)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .enable     (enable),
      .dir        (dir),
      .brake      (brake),
      .hall       (hall),
      .pwm_in     (pwm_in),
      .dead_time  (dead_time),
      .fault_clear(fault_clear),
      .gh         (gh),
      .gl         (gl),
      .sector     (sector),
      .step_pulse (step_pulse),
      .step_period(step_period),
      .fault      (fault),
      .seq_error  (seq_error)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_gates(input string tag, input logic [2:0] egh, input logic [2:0] egl);
      chk({tag, "_gh"}, 32'(gh), 32'(egh));
      chk({tag, "_gl"}, 32'(gl), 32'(egl));
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      dir         = 1'b1;
      brake       = 1'b0;
      hall        = 3'b100;
      pwm_in      = 1'b1;
      dead_time   = 10'd5;
      fault_clear = 1'b0;
      tick();
      tick();

      // Reset state
      chk_gates("rst", 3'b000, 3'b000);
      chk("rst_sector", 32'(sector), 32'd0);
      chk("rst_pulse", 32'(step_pulse), 32'd0);
      chk("rst_period", 32'(step_period), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_seq", 32'(seq_error), 32'd0);
      reset = 1'b0;

      // E1: first hall decode after reset, count since reset is 0
      tick();
      chk("e1_sector", 32'(sector), 32'd1);
      chk("e1_pulse", 32'(step_pulse), 32'd1);
      chk("e1_period", 32'(step_period), 32'd0);
      tick();
      chk("e2_pulse", 32'(step_pulse), 32'd0);

      // Enable: five all-off cycles, then sector 1 forward A/B
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_gates("dt_start", 3'b000, 3'b000);
      end
      tick();
      chk_gates("drive_s1", 3'b001, 3'b010);

      // Hall 100 -> 110 while driving
      hall = 3'b110;
      tick();
      chk("e9_pulse", 32'(step_pulse), 32'd1);
      chk("e9_period", 32'(step_period), 32'd8);
      chk("e9_sector", 32'(sector), 32'd2);
      chk_gates("e9_still", 3'b001, 3'b010);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_gates("dt_s2", 3'b000, 3'b000);
         if (i == 0) chk("e10_pulse", 32'(step_pulse), 32'd0);
      end
      tick();
      chk_gates("drive_s2", 3'b001, 3'b100);

      // Back to sector 1
      hall = 3'b100;
      tick();
      chk("e16_period", 32'(step_period), 32'd7);
      for (int i = 0; i < 5; i++) tick();
      tick();
      chk_gates("drive_s1b", 3'b001, 3'b010);

      // dir 1 -> 0 with dead_time 0: exactly one all-off cycle
      dir       = 1'b0;
      dead_time = 10'd0;
      tick();
      chk_gates("dir_gap", 3'b000, 3'b000);
      tick();
      chk_gates("drive_s1_rev", 3'b010, 3'b001);

      // pwm_in gates only the high side
      pwm_in = 1'b0;
      #1;
      chk_gates("pwm_off", 3'b000, 3'b001);
      pwm_in = 1'b1;
      #1;

      // Invalid hall for 16 cycles
      hall = 3'b111;
      for (int i = 0; i < 15; i++) tick();
      chk("inv15_fault", 32'(fault), 32'd0);
      chk("inv15_sector", 32'(sector), 32'd1);
      chk_gates("inv15", 3'b010, 3'b001);
      tick();
      chk("inv16_fault", 32'(fault), 32'd1);
      chk_gates("inv16", 3'b000, 3'b000);

      // fault_clear with invalid hall is ignored
      fault_clear = 1'b1;
      tick();
      chk("clr_ignored", 32'(fault), 32'd1);
      chk_gates("clr_ignored", 3'b000, 3'b000);

      // fault_clear with hall 101 clears and re-drives after dead time
      hall = 3'b101;
      tick();
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_sector", 32'(sector), 32'd0);
      chk("clr_period", 32'(step_period), 32'd26);
      chk_gates("clr", 3'b000, 3'b000);
      fault_clear = 1'b0;
      dead_time   = 10'd2;
      tick();
      chk_gates("redrive_dt0", 3'b000, 3'b000);
      tick();
      chk_gates("redrive_dt1", 3'b000, 3'b000);
      tick();
      chk_gates("drive_s0_rev", 3'b010, 3'b100);

      // Skip 0 -> 2
      hall = 3'b110;
      tick();
      chk("skip_period", 32'(step_period), 32'd4);
      chk("skip_seq", 32'(seq_error), EXP_SEQ);
      tick();
      tick();
      tick();
      chk_gates("drive_s2_rev", 3'b100, 3'b001);
      chk("skip_seq_hold", 32'(seq_error), EXP_SEQ);

      // Brake while driving
      brake = 1'b1;
      tick();
      chk_gates("brake_gap", 3'b000, 3'b000);
      tick();
      tick();
      chk_gates("brake_on", 3'b000, 3'b111);

      // Brake release, then enable=0 in the middle of the gap
      brake = 1'b0;
      tick();
      chk_gates("unbrake_gap", 3'b000, 3'b000);
      enable = 1'b0;
      tick();
      chk_gates("disable", 3'b000, 3'b000);

      // Re-enable: a full two-cycle gap again shows the FSM went to IDLE
      enable = 1'b1;
      tick();
      chk_gates("reen_dt0", 3'b000, 3'b000);
      tick();
      chk_gates("reen_dt1", 3'b000, 3'b000);
      tick();
      chk_gates("reen_drive", 3'b100, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
